// File: rtl/memshare_vn_iblut_remap_loader_pkg.sv
// Shared sizing constants and loader state encoding for one share-group rank.
`default_nettype none

package memShare_config_pkg;

  localparam int QUAN_SIZE         = 4;
  localparam int SHARE_GROUP_SIZE  = 4;
  localparam int GP2_COL_SEL_WIDTH = 1;
  localparam int PAGE_NUM          = 2 ** GP2_COL_SEL_WIDTH;
  localparam int REMAP_BEAT_NUM    = PAGE_NUM * (2 ** QUAN_SIZE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } remap_loader_state_e;

endpackage

`default_nettype wire

// File: rtl/memshare_remap_addr_gen.sv
// {page down-counter, c2v up-counter} walking the IB-RAM remap address space.
`default_nettype none

module memshare_remap_addr_gen #(
  parameter int QUAN_SIZE         = 4,
  parameter int GP2_COL_SEL_WIDTH = 1,
  parameter int PAGE_NUM          = 2 ** GP2_COL_SEL_WIDTH
) (
  input  logic                         sys_clk,
  input  logic                         rst,
  input  logic                         init_i,
  input  logic                         advance_i,
  output logic [GP2_COL_SEL_WIDTH-1:0] page_o,
  output logic [QUAN_SIZE-1:0]         c2v_o,
  output logic                         last_o
);

  localparam logic [GP2_COL_SEL_WIDTH-1:0] PAGE_TOP = GP2_COL_SEL_WIDTH'(PAGE_NUM - 1);

  logic [GP2_COL_SEL_WIDTH-1:0] page_q;
  logic [QUAN_SIZE-1:0]         c2v_q;

  // Highest page first so page 0 is the final content seen by c2v-only lanes.
  always_ff @(posedge sys_clk) begin
    if (rst || init_i) begin
      page_q <= PAGE_TOP;
      c2v_q  <= '0;
    end else if (advance_i) begin
      c2v_q <= c2v_q + 1'b1;
      if (c2v_q == '1) begin
        page_q <= page_q - 1'b1;
      end
    end
  end

  assign page_o = page_q;
  assign c2v_o  = c2v_q;
  assign last_o = (page_q == '0) && (c2v_q == '1);

endmodule

`default_nettype wire

// File: rtl/memshare_vn_iblut_remap_loader.sv
// Streams an IB-LUT image into every VN IB-RAM of a rank via the remap write port.
`default_nettype none

module memshare_vn_iblut_remap_loader #(
  parameter int QUAN_SIZE         = memShare_config_pkg::QUAN_SIZE,
  parameter int SHARE_GROUP_SIZE  = memShare_config_pkg::SHARE_GROUP_SIZE,
  parameter int GP2_COL_SEL_WIDTH = memShare_config_pkg::GP2_COL_SEL_WIDTH,
  parameter int PAGE_NUM          = 2 ** GP2_COL_SEL_WIDTH
) (
  input  logic                                          sys_clk,
  input  logic                                          rst,
  input  logic                                          start_i,
  output logic                                          busy_o,
  output logic                                          done_o,
  input  logic [QUAN_SIZE*SHARE_GROUP_SIZE-1:0]         s_data_i,
  input  logic                                          s_valid_i,
  output logic                                          s_ready_o,
  output logic [QUAN_SIZE*SHARE_GROUP_SIZE-1:0]         remap_dataIn_vec_o,
  output logic [GP2_COL_SEL_WIDTH*SHARE_GROUP_SIZE-1:0] memShare_colSel_vec_o,
  output logic [QUAN_SIZE*SHARE_GROUP_SIZE-1:0]         c2v_msg_vec_o,
  output logic                                          nRemap_en_o
);

  import memShare_config_pkg::*;

  remap_loader_state_e state_q, state_d;

  logic                         accept;
  logic                         init;
  logic                         last;
  logic [GP2_COL_SEL_WIDTH-1:0] page;
  logic [QUAN_SIZE-1:0]         c2v;

  logic [QUAN_SIZE*SHARE_GROUP_SIZE-1:0]         data_q;
  logic [GP2_COL_SEL_WIDTH*SHARE_GROUP_SIZE-1:0] colsel_q;
  logic [QUAN_SIZE*SHARE_GROUP_SIZE-1:0]         c2v_vec_q;
  logic                                          nremap_q;
  logic                                          done_q;

  assign accept = (state_q == LOAD) && s_valid_i;
  assign init   = (state_q == IDLE) && start_i;

  memshare_remap_addr_gen #(
    .QUAN_SIZE        (QUAN_SIZE),
    .GP2_COL_SEL_WIDTH(GP2_COL_SEL_WIDTH),
    .PAGE_NUM         (PAGE_NUM)
  ) u_addr_gen (
    .sys_clk  (sys_clk),
    .rst      (rst),
    .init_i   (init),
    .advance_i(accept),
    .page_o   (page),
    .c2v_o    (c2v),
    .last_o   (last)
  );

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = LOAD;
      LOAD:    if (accept && last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Write port: data/address captured with the beat, held while the strobe is idle.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      data_q    <= '0;
      colsel_q  <= '0;
      c2v_vec_q <= '0;
      nremap_q  <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      nremap_q <= ~accept;
      done_q   <= (state_q == DONE);
      if (accept) begin
        data_q    <= s_data_i;
        colsel_q  <= {SHARE_GROUP_SIZE{page}};
        c2v_vec_q <= {SHARE_GROUP_SIZE{c2v}};
      end
    end
  end

  assign busy_o                = (state_q != IDLE);
  assign s_ready_o             = (state_q == LOAD);
  assign done_o                = done_q;
  assign remap_dataIn_vec_o    = data_q;
  assign memShare_colSel_vec_o = colsel_q;
  assign c2v_msg_vec_o         = c2v_vec_q;
  assign nRemap_en_o           = nremap_q;

endmodule

`default_nettype wire
